// File: rtl/chunked_add_seq_if.sv
// Operand/result handshake bundle for chunked_add_seq.
// N must match the N of the chunked_add_seq instance it is bound to.
interface chunked_add_seq_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  cout
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output cout
    );
endinterface

// File: rtl/chunked_add_seq.sv
// N-bit adder built from one W-bit ripple slice reused over N/W cycles,
// LSB chunk first, with a registered carry between chunks.
module chunked_add_seq #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    chunked_add_seq_if.slave   io,
    output logic               busy
);
    localparam int NC = N / W;
    localparam int CW = (NC > 1) ? $clog2(NC) : 1;

    if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_param_err
        $error("chunked_add_seq: N must be a positive multiple of W");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic [CW-1:0] cnt_q, cnt_d;

    int            base;
    logic [W-1:0]  slice_a;
    logic [W-1:0]  slice_b;
    logic [W-1:0]  slice_s;
    logic          slice_c;
    logic          last;

    assign base = int'(cnt_q) * W;
    assign last = (cnt_q == CW'(NC - 1));

    // One W-cell full-adder chain; the carry ripples bit by bit.
    always_comb begin
        logic c;
        slice_a = a_q[base +: W];
        slice_b = b_q[base +: W];
        slice_s = '0;
        c       = carry_q;
        for (int i = 0; i < W; i++) begin
            slice_s[i] = slice_a[i] ^ slice_b[i] ^ c;
            c = (slice_a[i] & slice_b[i]) |
                (c & (slice_a[i] ^ slice_b[i]));
        end
        slice_c = c;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    a_d     = io.a;
                    b_d     = io.b;
                    carry_d = io.cin;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[base +: W] = slice_s;
                carry_d = slice_c;
                // Counter parks on the last chunk instead of wrapping.
                if (last) begin
                    cout_d  = slice_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.sum       = sum_q;
    assign io.cout      = cout_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_chunked_add_seq.sv
// Bench for chunked_add_seq: directed cases on N=32/W=8 plus a random
// sweep over four N/W configurations against an arithmetic model.
module tb_chunked_add_seq;
    logic clk;
    logic rst_n;

    logic [31:0] a_v    [4];
    logic [31:0] b_v    [4];
    logic        cin_v  [4];
    logic        iv_v   [4];
    logic        ordy_v [4];
    logic        ir_v   [4];
    logic        ov_v   [4];
    logic        co_v   [4];
    logic        bz_v   [4];
    logic [31:0] s_v    [4];

    int n_cmp = 0;
    int n_err = 0;

    chunked_add_seq_if #(.N(32)) if0 ();
    chunked_add_seq_if #(.N(8))  if1 ();
    chunked_add_seq_if #(.N(32)) if2 ();
    chunked_add_seq_if #(.N(16)) if3 ();

    assign if0.a = a_v[0];
    assign if0.b = b_v[0];
    assign if1.a = a_v[1][7:0];
    assign if1.b = b_v[1][7:0];
    assign if2.a = a_v[2];
    assign if2.b = b_v[2];
    assign if3.a = a_v[3][15:0];
    assign if3.b = b_v[3][15:0];

    assign if0.cin = cin_v[0];
    assign if1.cin = cin_v[1];
    assign if2.cin = cin_v[2];
    assign if3.cin = cin_v[3];
    assign if0.in_valid = iv_v[0];
    assign if1.in_valid = iv_v[1];
    assign if2.in_valid = iv_v[2];
    assign if3.in_valid = iv_v[3];
    assign if0.out_ready = ordy_v[0];
    assign if1.out_ready = ordy_v[1];
    assign if2.out_ready = ordy_v[2];
    assign if3.out_ready = ordy_v[3];

    assign ir_v[0] = if0.in_ready;
    assign ir_v[1] = if1.in_ready;
    assign ir_v[2] = if2.in_ready;
    assign ir_v[3] = if3.in_ready;
    assign ov_v[0] = if0.out_valid;
    assign ov_v[1] = if1.out_valid;
    assign ov_v[2] = if2.out_valid;
    assign ov_v[3] = if3.out_valid;
    assign co_v[0] = if0.cout;
    assign co_v[1] = if1.cout;
    assign co_v[2] = if2.cout;
    assign co_v[3] = if3.cout;
    assign s_v[0]  = if0.sum;
    assign s_v[1]  = {24'b0, if1.sum};
    assign s_v[2]  = if2.sum;
    assign s_v[3]  = {16'b0, if3.sum};

    chunked_add_seq #(.N(32), .W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .io(if0), .busy(bz_v[0]));
    chunked_add_seq #(.N(8), .W(1)) u1 (
        .clk(clk), .rst_n(rst_n), .io(if1), .busy(bz_v[1]));
    chunked_add_seq #(.N(32), .W(32)) u2 (
        .clk(clk), .rst_n(rst_n), .io(if2), .busy(bz_v[2]));
    chunked_add_seq #(.N(16), .W(4)) u3 (
        .clk(clk), .rst_n(rst_n), .io(if3), .busy(bz_v[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int nc_of(input int k);
        case (k)
            0: return 4;
            1: return 8;
            2: return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int wid_of(input int k);
        case (k)
            0: return 32;
            1: return 8;
            2: return 32;
            default: return 16;
        endcase
    endfunction

    task automatic model(input int k, input logic [31:0] a,
                         input logic [31:0] b, input logic ci,
                         output logic [31:0] s, output logic c);
        logic [63:0] m;
        logic [63:0] t;
        m = (64'd1 << wid_of(k)) - 64'd1;
        t = (64'(a) & m) + (64'(b) & m) + 64'(ci);
        s = 32'(t & m);
        c = t[wid_of(k)];
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready(input int k);
        for (int i = 0; i < 50 && !ir_v[k]; i++) step();
        chk($sformatf("k%0d in_ready", k), 64'(ir_v[k]), 64'd1);
    endtask

    task automatic wait_valid(input int k, output int lat);
        lat = 1;
        while (!ov_v[k] && lat < 200) begin
            step();
            lat++;
        end
    endtask

    task automatic do_txn(input int k, input logic [31:0] a,
                          input logic [31:0] b, input logic ci,
                          input bit rnd);
        logic [31:0] es;
        logic        ec;
        int          lat;
        int          hold;
        bit          early;
        model(k, a, b, ci, es, ec);
        early = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        hold  = (rnd && !early) ? int'($urandom_range(0, 3)) : 0;
        wait_ready(k);
        a_v[k] = a; b_v[k] = b; cin_v[k] = ci;
        iv_v[k] = 1'b1;
        ordy_v[k] = early;
        step();
        iv_v[k] = 1'b0;
        a_v[k] = $urandom; b_v[k] = $urandom;
        cin_v[k] = 1'($urandom);
        wait_valid(k, lat);
        chk($sformatf("k%0d latency", k), 64'(lat), 64'(nc_of(k) + 1));
        chk($sformatf("k%0d sum", k), 64'(s_v[k]), 64'(es));
        chk($sformatf("k%0d cout", k), 64'(co_v[k]), 64'(ec));
        for (int i = 0; i < hold; i++) begin
            step();
            chk($sformatf("k%0d hold sum", k), 64'(s_v[k]), 64'(es));
            chk($sformatf("k%0d hold valid", k), 64'(ov_v[k]), 64'd1);
        end
        ordy_v[k] = 1'b1;
        step();
        chk($sformatf("k%0d valid drop", k), 64'(ov_v[k]), 64'd0);
        chk($sformatf("k%0d idle ready", k), 64'(ir_v[k]), 64'd1);
        chk($sformatf("k%0d sum kept", k), 64'(s_v[k]), 64'(es));
        ordy_v[k] = 1'b0;
    endtask

    initial begin
        logic [31:0] es;
        logic [31:0] es2;
        logic        ec;
        int          lat;
        for (int k = 0; k < 4; k++) begin
            a_v[k] = '0; b_v[k] = '0; cin_v[k] = 1'b0;
            iv_v[k] = 1'b0; ordy_v[k] = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("k%0d rst in_ready", k), 64'(ir_v[k]), 64'd1);
            chk($sformatf("k%0d rst out_valid", k), 64'(ov_v[k]), 64'd0);
            chk($sformatf("k%0d rst busy", k), 64'(bz_v[k]), 64'd0);
            chk($sformatf("k%0d rst sum", k), 64'(s_v[k]), 64'd0);
            chk($sformatf("k%0d rst cout", k), 64'(co_v[k]), 64'd0);
        end
        rst_n = 1'b1;
        step();

        // Wrap/overflow and carry isolation, with literal expectations.
        do_txn(0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        model(0, 32'hFFFF_FFFF, 32'h0, 1'b1, es, ec);
        chk("wrap model", {31'b0, ec, es}, {31'b0, 1'b1, 32'h0});
        do_txn(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        model(0, 32'h1234_5678, 32'h1111_1111, 1'b0, es, ec);
        chk("iso model", {31'b0, ec, es}, {31'b0, 1'b0, 32'h2345_6789});
        do_txn(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);

        // Backpressure: out_ready low for 10 cycles in DONE.
        model(0, 32'h8000_0001, 32'h8000_0002, 1'b1, es, ec);
        wait_ready(0);
        a_v[0] = 32'h8000_0001; b_v[0] = 32'h8000_0002;
        cin_v[0] = 1'b1; iv_v[0] = 1'b1;
        step();
        iv_v[0] = 1'b0;
        wait_valid(0, lat);
        chk("bp latency", 64'(lat), 64'd5);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp sum", 64'(s_v[0]), 64'(es));
            chk("bp cout", 64'(co_v[0]), 64'(ec));
            chk("bp in_ready", 64'(ir_v[0]), 64'd0);
            chk("bp busy", 64'(bz_v[0]), 64'd1);
        end
        ordy_v[0] = 1'b1;
        step();
        ordy_v[0] = 1'b0;
        chk("bp valid drop", 64'(ov_v[0]), 64'd0);
        chk("bp idle ready", 64'(ir_v[0]), 64'd1);
        chk("bp idle busy", 64'(bz_v[0]), 64'd0);

        // Busy rejection: second operand set held during RUN.
        model(0, 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, es, ec);
        model(0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, es2, ec);
        wait_ready(0);
        a_v[0] = 32'h0F0F_0F0F; b_v[0] = 32'h0101_0101;
        cin_v[0] = 1'b0; iv_v[0] = 1'b1;
        step();
        a_v[0] = 32'hDEAD_BEEF; b_v[0] = 32'h1234_5678;
        cin_v[0] = 1'b1;
        chk("rej in_ready", 64'(ir_v[0]), 64'd0);
        wait_valid(0, lat);
        chk("rej sum first", 64'(s_v[0]), 64'(es));
        ordy_v[0] = 1'b1;
        step();
        ordy_v[0] = 1'b0;
        chk("rej idle ready", 64'(ir_v[0]), 64'd1);
        step();
        iv_v[0] = 1'b0;
        wait_valid(0, lat);
        chk("rej latency", 64'(lat), 64'd5);
        chk("rej sum second", 64'(s_v[0]), 64'(es2));
        ordy_v[0] = 1'b1;
        step();
        ordy_v[0] = 1'b0;

        // Reset pulse during the second RUN cycle.
        wait_ready(0);
        a_v[0] = 32'h0102_0304; b_v[0] = 32'h0000_0010;
        cin_v[0] = 1'b0; iv_v[0] = 1'b1;
        ordy_v[0] = 1'b1;
        step();
        iv_v[0] = 1'b0;
        step();
        chk("mid partial sum", 64'(s_v[0]), 64'h14);
        chk("mid busy", 64'(bz_v[0]), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid rst in_ready", 64'(ir_v[0]), 64'd1);
        chk("mid rst out_valid", 64'(ov_v[0]), 64'd0);
        chk("mid rst busy", 64'(bz_v[0]), 64'd0);
        chk("mid rst sum", 64'(s_v[0]), 64'd0);
        chk("mid rst cout", 64'(co_v[0]), 64'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("mid no valid", 64'(ov_v[0]), 64'd0);
        end
        ordy_v[0] = 1'b0;
        do_txn(0, 32'hCAFE_F00D, 32'h3501_0FF3, 1'b1, 1'b0);

        // Random back-to-back sweep over all configurations.
        for (int k = 0; k < 4; k++) begin
            do_txn(k, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
            do_txn(k, 32'h0, 32'h0, 1'b0, 1'b1);
            for (int i = 0; i < 15; i++) begin
                do_txn(k, $urandom, $urandom, 1'($urandom), 1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/chunked_add_seq.md
Name: chunked_add_seq

Overview:
- Multi-cycle sequencer that adds two N-bit operands with one W-bit ripple-carry adder slice, reused over N/W consecutive cycles.
- The slice is W full-adder cells.
- Chunks are processed LSB first, with a registered carry passed between chunks.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades latency for area in place of an N-bit adder instance.

Parameters:
- N, 32, operand/result width. Must be a multiple of W; any other value is an elaboration error.
- W, 8, adder slice width per cycle (1 <= W <= N).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  N  operand A; sampled on input handshake.
- b  input  N  operand B; sampled on input handshake.
- cin  input  1  carry-in to chunk 0; sampled on input handshake.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  N  registered result a+b+cin, modulo 2^N.
- cout  output  1  registered carry-out of the top chunk.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - State = IDLE.
  - in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
  - Chunk counter=0, carry register=0, operand registers=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b and cin (cin goes into the carry register), clear the chunk counter, clear the sum register, go to RUN.
  - RUN: in_ready=0. Each cycle, compute chunk k = counter, bits [k*W +: W]:
    - {c, s} = a_chunk + b_chunk + carry.
    - Write s into sum[k*W +: W]; carry <= c; counter++.
    - When k == N/W-1: cout <= c, go to DONE.
  - DONE: out_valid=1. sum and cout must stay stable until out_valid&&out_ready. On that handshake, go to IDLE.
- Latency and throughput:
  - Input handshake on edge T puts the block in RUN at T+1.
  - out_valid rises after exactly N/W RUN cycles.
  - With W=N: one RUN cycle, out_valid asserted 2 edges after acceptance.
  - No overlap: the next input is accepted at the earliest one cycle after the output handshake.
  - in_ready is 0 in the DONE cycle where the output handshake happens.
  - Max throughput is one result per N/W+2 cycles.
- Output stability:
  - sum and cout are registered outputs.
  - While in RUN, sum holds partial values and is not meaningful; consumers use it only when out_valid=1.
  - After the output handshake, sum and cout keep their last values until the next acceptance clears sum.
- Arithmetic:
  - Unsigned, no saturation. Overflow is reported only via cout.
  - Chunk carry is exactly the full-adder carry chain over W bits.
- Boundaries:
  - in_valid while busy: ignored, not latched. The producer must hold it until in_ready.
  - Changes to a, b or cin during RUN have no effect.
  - out_ready held high before DONE: the handshake completes in the first DONE cycle.
  - out_ready low indefinitely: remain in DONE with all outputs frozen.
  - The counter must not wrap during RUN. It resets to 0 on each acceptance.
  - rst_n asserted in any state, including mid-RUN: immediate return to reset values. The partial result is discarded and no out_valid pulse follows.

Test Plan:
- Wrap and overflow (N=32, W=8): a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1. out_valid rises exactly 5 edges after the input-handshake edge.
- Per-chunk carry isolation: a=0x12345678, b=0x11111111, cin=0 -> sum=0x23456789, cout=0. Then a=0x000000FF, b=0x00000001 -> sum=0x00000100, checking carry propagation chunk0->chunk1.
- Backpressure:
  - With out_ready=0 for 10 cycles after out_valid, sum and cout stay constant, in_ready=0 and busy=1 throughout.
  - Raise out_ready: out_valid falls next edge and in_ready=1 in IDLE.
- Busy rejection: after acceptance, drive in_valid=1 with new a/b during RUN -> not captured. Result matches the first operands; the second set is accepted only after return to IDLE.
- Mid-operation reset: pulse rst_n low during the 2nd RUN cycle -> all outputs return to reset values asynchronously (before the next edge). No out_valid afterwards; a new transaction completes correctly.
- Parameter sweep with random back-to-back transactions, out_ready randomised: (N=8, W=1), (N=32, W=32), (N=16, W=4). Every result equals reference a+b+cin, and latency equals N/W+1 edges in each case.
